// File: rtl/adder_pkg.sv
// Shared definitions for the ripple-carry adder datapath and its result buffer.
package adder_pkg;

  localparam int RCA_WIDTH = 8;
  localparam int RESULT_W  = RCA_WIDTH + 1;

  typedef struct packed {
    logic                 cout;
    logic [RCA_WIDTH-1:0] sum;
  } rca_result_t;

  function automatic rca_result_t packResult(input logic cout, input logic [RCA_WIDTH-1:0] sum);
    rca_result_t r;
    r.cout = cout;
    r.sum  = sum;
    return r;
  endfunction

endpackage

// File: rtl/adder_result_buffer_if.sv
// Adder-result handshake bundle: upstream push side, downstream pop side, status.
interface adder_result_buffer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_sum;
  logic             io_in_cout;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH:0]   io_out_bits;
  logic [CW-1:0]    io_count;
  logic             io_ovf_clear;
  logic [7:0]       io_ovf_count;

  // Driving side: the adder/parent and the consumer.
  modport master (
    output io_in_valid, io_in_sum, io_in_cout, io_out_ready, io_ovf_clear,
    input  io_in_ready, io_out_valid, io_out_bits, io_count, io_ovf_count
  );

  // Buffer side.
  modport slave (
    input  io_in_valid, io_in_sum, io_in_cout, io_out_ready, io_ovf_clear,
    output io_in_ready, io_out_valid, io_out_bits, io_count, io_ovf_count
  );

endinterface

// File: rtl/adder_result_store.sv
// DEPTH x WORD_W register array with one synchronous write port and one async read port.
module adder_result_store #(
  parameter int WORD_W = 9,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wrEn,
  input  logic [AW-1:0]     wrAddr,
  input  logic [WORD_W-1:0] wrData,
  input  logic [AW-1:0]     rdAddr,
  output logic [WORD_W-1:0] rdData
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; occupancy tracking makes stale entries unobservable.
  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/adder_result_buffer.sv
// Result FIFO behind the ripple-carry adder; optional overflow counter under
// ADDER_RESULT_OVF_COUNT_EN.
module adder_result_buffer
  import adder_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  adder_result_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Ready/valid come from registered occupancy only, so no comb path crosses the buffer.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.io_in_valid & ~full;
  assign pop   = bus.io_out_ready & ~empty;

  assign bus.io_in_ready  = ~full;
  assign bus.io_out_valid = ~empty;
  assign bus.io_count     = count;

  adder_result_store #(
    .WORD_W (WIDTH + 1),
    .DEPTH  (DEPTH)
  ) store (
    .clock  (clock),
    .wrEn   (push),
    .wrAddr (wrPtr),
    .wrData ({bus.io_in_cout, bus.io_in_sum}),
    .rdAddr (rdPtr),
    .rdData (bus.io_out_bits)
  );

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef ADDER_RESULT_OVF_COUNT_EN
  logic [7:0] ovfCount;

  // Clear wins over a same-cycle increment; the counter saturates rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset || bus.io_ovf_clear) begin
      ovfCount <= '0;
    end else if (push && bus.io_in_cout && ovfCount != 8'hFF) begin
      ovfCount <= ovfCount + 8'd1;
    end
  end

  assign bus.io_ovf_count = ovfCount;
`else
  logic unusedOvfClear;

  assign unusedOvfClear   = bus.io_ovf_clear;
  assign bus.io_ovf_count = 8'h00;
`endif

endmodule

// File: tb/tb_adder_result_buffer.sv
// Bench for adder_result_buffer: directed scenarios plus random traffic against a queue model.
module tb_adder_result_buffer;
  import adder_pkg::*;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  adder_result_buffer_if #(.WIDTH(RCA_WIDTH), .DEPTH(DEPTH)) bus ();

  adder_result_buffer #(.WIDTH(RCA_WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int nCompared   = 0;
  int nMismatched = 0;

  rca_result_t q[$];
  int          ovfModel   = 0;
  bit          modelValid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] s, input bit c, input bit ordy, input bit clr);
    bus.io_in_valid  = v;
    bus.io_in_sum    = s;
    bus.io_in_cout   = c;
    bus.io_out_ready = ordy;
    bus.io_ovf_clear = clr;
  endtask

  // One clock: compare DUT to model mid-cycle, then advance the model by the edge's effect.
  task automatic cycle();
    bit          acc;
    bit          popd;
    bit          clr;
    bit          rst;
    rca_result_t word;
    @(negedge clock);
    if (modelValid) begin
      check("out_valid", 32'(bus.io_out_valid), 32'(q.size() != 0));
      check("in_ready",  32'(bus.io_in_ready),  32'(q.size() < DEPTH));
      check("count",     32'(bus.io_count),     32'(q.size()));
      check("ovf_count", 32'(bus.io_ovf_count), 32'(ovfModel));
      if (q.size() != 0) check("out_bits", 32'(bus.io_out_bits), 32'(q[0]));
    end
    rst  = reset;
    acc  = bus.io_in_valid && (q.size() < DEPTH);
    popd = bus.io_out_ready && (q.size() > 0);
    clr  = bus.io_ovf_clear;
    word = packResult(bus.io_in_cout, bus.io_in_sum);
    @(posedge clock);
    #1;
    if (rst) begin
      q.delete();
      ovfModel   = 0;
      modelValid = 1'b1;
    end else begin
      if (popd) void'(q.pop_front());
      if (acc)  q.push_back(word);
`ifdef ADDER_RESULT_OVF_COUNT_EN
      if (clr) ovfModel = 0;
      else if (acc && word.cout && ovfModel < 255) ovfModel++;
`endif
    end
  endtask

  task automatic drain();
    drive(0, 8'h00, 0, 1, 0);
    repeat (DEPTH + 1) cycle();
  endtask

  initial begin
    int expOvf;
    drive(0, 8'h00, 0, 0, 0);
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    check("reset_count", 32'(bus.io_count), 32'd0);
    check("reset_ready", 32'(bus.io_in_ready), 32'd1);

    // Single push becomes visible the following cycle.
    drive(1, 8'h2A, 0, 0, 0);
    cycle();
    drive(0, 8'h00, 0, 0, 0);
    check("t1_valid", 32'(bus.io_out_valid), 32'd1);
    check("t1_bits",  32'(bus.io_out_bits),  32'h02A);
    check("t1_count", 32'(bus.io_count),     32'd1);
    drain();

    // Fill to full; a fifth word is held off.
    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'(i), 0, 0, 0);
      cycle();
    end
    drive(1, 8'h05, 0, 0, 0);
    cycle();
    check("t2_count", 32'(bus.io_count),    32'd4);
    check("t2_ready", 32'(bus.io_in_ready), 32'd0);

    // Pop while full does not admit the waiting word that cycle.
    drive(1, 8'h05, 0, 1, 0);
    cycle();
    check("t3_count", 32'(bus.io_count),    32'd3);
    check("t3_head",  32'(bus.io_out_bits), 32'h002);
    drive(1, 8'h05, 0, 0, 0);
    cycle();
    check("t3_refill", 32'(bus.io_count), 32'd4);
    drain();

    // Streaming push+pop through the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(8'h10 + i), 0, 1, 0);
      cycle();
      check("t4_count", 32'(bus.io_count), 32'd1);
    end
    drain();

    // Overflow counting and clear priority.
    repeat (3) begin
      drive(1, 8'hFE, 1, 1, 0);
      cycle();
    end
`ifdef ADDER_RESULT_OVF_COUNT_EN
    expOvf = 3;
`else
    expOvf = 0;
`endif
    check("t5_ovf3", 32'(bus.io_ovf_count), 32'(expOvf));
    drive(1, 8'hFE, 1, 1, 1);
    cycle();
    check("t5_clear", 32'(bus.io_ovf_count), 32'd0);
    drain();

    // Reset with entries queued, then reuse.
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(8'h60 + i), 0, 0, 0);
      cycle();
    end
    drive(0, 8'h00, 0, 0, 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t6_valid", 32'(bus.io_out_valid), 32'd0);
    check("t6_count", 32'(bus.io_count),     32'd0);
    check("t6_ready", 32'(bus.io_in_ready),  32'd1);
    drive(1, 8'h77, 0, 0, 0);
    cycle();
    check("t6_bits", 32'(bus.io_out_bits), 32'h077);
    drain();

    // Saturation of the overflow counter.
    drive(1, 8'hFF, 1, 1, 0);
    repeat (300) cycle();
`ifdef ADDER_RESULT_OVF_COUNT_EN
    expOvf = 255;
`else
    expOvf = 0;
`endif
    check("sat_ovf", 32'(bus.io_ovf_count), 32'(expOvf));
    drain();

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 600; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), 8'($urandom), bit'($urandom),
            bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 40) == 0));
      reset = ($urandom_range(0, 150) == 0);
      cycle();
    end
    reset = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
